// File: rtl/ucode_pkg.sv
// Shared definitions for the microcode field decoder: the mode encodings,
// the default widths, and the selector-width to output-count helper.
package ucode_pkg;

    // Per-field mode encodings as seen on the mode input.
    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

    // Default selector width and pulse-length width.
    localparam int SEL_W_DEF  = 3;
    localparam int HOLD_W_DEF = 4;

    // Number of one-hot outputs driven by a selector of the given width.
    function automatic int nout_f(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/ucode_field_reg.sv
// One decoded microcode field. It detects the falling edge of the field
// strobe and latches the selector decode into a registered active-low
// one-hot output. In pulse mode a down-counter returns the outputs high
// after the programmed number of cycles.
module ucode_field_reg
    import ucode_pkg::*;
#(
    parameter  int SEL_W  = SEL_W_DEF,
    parameter  int HOLD_W = HOLD_W_DEF,
    localparam int NOUT   = nout_f(SEL_W)
) (
    input  logic              main_clk,
    input  logic              res,
    input  logic              strobe_n,
    input  logic              field_en,
    input  logic              mode,
    input  logic [SEL_W-1:0]  field_sel,
    input  logic [HOLD_W-1:0] hold_len,
    output logic [NOUT-1:0]   out_n,
    output logic              busy,
    output logic              overrun_evt
);

    logic              strobe_prev_q;
    logic [NOUT-1:0]   out_q;
    logic [NOUT-1:0]   out_d;
    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;
    logic              capture;
    logic [HOLD_W-1:0] load_len;

    // Capture detection, decode and hold-counter next state.
    always_comb begin
        capture     = strobe_prev_q & ~strobe_n;
        // A zero length still has to produce a visible one-cycle pulse.
        load_len    = (hold_len == '0) ? HOLD_W'(1) : hold_len;
        out_d       = out_q;
        cnt_d       = cnt_q;
        overrun_evt = 1'b0;
        if (capture) begin
            // A count of one means this edge is the expiry edge, so the
            // timer has already finished and a recapture is not an overrun.
            overrun_evt = (cnt_q > HOLD_W'(1));
            out_d       = '1;
            if (field_en) begin
                out_d[field_sel] = 1'b0;
            end
            cnt_d = (field_en && (mode == MODE_PULSE)) ? load_len : '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - HOLD_W'(1);
            if (cnt_q == HOLD_W'(1)) begin
                out_d = '1;
            end
        end
    end

    // State registers; reset aborts any pulse and suppresses a stale strobe.
    always_ff @(posedge main_clk or posedge res) begin
        if (res) begin
            strobe_prev_q <= 1'b0;
            out_q         <= '1;
            cnt_q         <= '0;
        end else begin
            strobe_prev_q <= strobe_n;
            out_q         <= out_d;
            cnt_q         <= cnt_d;
        end
    end

    assign out_n = out_q;
    assign busy  = (cnt_q != '0);

endmodule

// File: rtl/ucode_field_dec.sv
// Microcode field decoder: FIELDS independent strobed one-hot decoders
// sharing one pulse length, plus a sticky overrun flag collecting
// recaptures of fields whose pulse timer was still running.
module ucode_field_dec
    import ucode_pkg::*;
#(
    parameter  int FIELDS = 4,
    parameter  int SEL_W  = SEL_W_DEF,
    parameter  int HOLD_W = HOLD_W_DEF,
    localparam int NOUT   = nout_f(SEL_W)
) (
    input  logic [0:0]             main_clk,
    input  logic [0:0]             res,
    input  logic [FIELDS*SEL_W-1:0] field_sel,
    input  logic [FIELDS-1:0]      field_en,
    input  logic [FIELDS-1:0]      strobe_n,
    input  logic [FIELDS-1:0]      mode,
    input  logic [HOLD_W-1:0]      hold_len,
    input  logic [0:0]             clr_overrun,
    output logic [FIELDS*NOUT-1:0] out_n,
    output logic [FIELDS-1:0]      busy,
    output logic [0:0]             overrun
);

    logic [FIELDS-1:0] evt;
    logic              overrun_q;
    logic              overrun_d;

    generate
        for (genvar gi = 0; gi < FIELDS; gi++) begin : g_field
            ucode_field_reg #(
                .SEL_W  (SEL_W),
                .HOLD_W (HOLD_W)
            ) u_field (
                .main_clk    (main_clk[0]),
                .res         (res[0]),
                .strobe_n    (strobe_n[gi]),
                .field_en    (field_en[gi]),
                .mode        (mode[gi]),
                .field_sel   (field_sel[gi*SEL_W +: SEL_W]),
                .hold_len    (hold_len),
                .out_n       (out_n[gi*NOUT +: NOUT]),
                .busy        (busy[gi]),
                .overrun_evt (evt[gi])
            );
        end
    endgenerate

    // Sticky overrun: a new event beats a simultaneous clear.
    always_comb begin
        overrun_d = overrun_q;
        if (|evt) begin
            overrun_d = 1'b1;
        end else if (clr_overrun[0]) begin
            overrun_d = 1'b0;
        end
    end

    // Overrun flag register.
    always_ff @(posedge main_clk[0] or posedge res[0]) begin
        if (res[0]) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_ucode_field_dec.sv
// Testbench for ucode_field_dec: a table of single-field captures with
// constant expectations, hand-written multi-cycle sequences, and random
// stimulus, all cross-checked every cycle against a time-based model.
module tb_ucode_field_dec;

    localparam int FIELDS = 4;
    localparam int SEL_W  = 3;
    localparam int HOLD_W = 4;
    localparam int NOUT   = 8;

    logic [0:0]              main_clk = 1'b0;
    logic [0:0]              res;
    logic [FIELDS*SEL_W-1:0] field_sel;
    logic [FIELDS-1:0]       field_en;
    logic [FIELDS-1:0]       strobe_n;
    logic [FIELDS-1:0]       mode;
    logic [HOLD_W-1:0]       hold_len;
    logic [0:0]              clr_overrun;
    logic [FIELDS*NOUT-1:0]  out_n;
    logic [FIELDS-1:0]       busy;
    logic [0:0]              overrun;

    always #5 main_clk = ~main_clk;

    ucode_field_dec #(
        .FIELDS (FIELDS),
        .SEL_W  (SEL_W),
        .HOLD_W (HOLD_W)
    ) dut (
        .main_clk    (main_clk),
        .res         (res),
        .field_sel   (field_sel),
        .field_en    (field_en),
        .strobe_n    (strobe_n),
        .mode        (mode),
        .hold_len    (hold_len),
        .clr_overrun (clr_overrun),
        .out_n       (out_n),
        .busy        (busy),
        .overrun     (overrun)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: each field remembers its current pattern and the absolute
    // edge number at which its pulse ends (outputs return high there).
    int              edge_num = 0;
    logic [NOUT-1:0] m_pat [FIELDS];
    int              m_end [FIELDS];
    bit              m_prev [FIELDS];
    bit              m_ovr;

    typedef struct {
        int              f;
        int              sel;
        bit              en;
        bit              md;
        int              hold;
        logic [NOUT-1:0] pat;
        int              low;
        int              bsy;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_num);
        end
    endtask

    function automatic logic [NOUT-1:0] low_at(input int sel);
        logic [NOUT-1:0] v;
        v = '1;
        v[sel] = 1'b0;
        return v;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < FIELDS; f++) begin
            m_pat[f]  = '1;
            m_end[f]  = 0;
            m_prev[f] = 1'b0;
        end
        m_ovr = 1'b0;
    endtask

    task automatic model_edge();
        bit any_ovr;
        any_ovr = 1'b0;
        edge_num++;
        for (int f = 0; f < FIELDS; f++) begin
            bit cap;
            int s;
            cap = m_prev[f] && !strobe_n[f];
            s   = int'(field_sel[f*SEL_W +: SEL_W]);
            if (cap) begin
                if (edge_num < m_end[f]) any_ovr = 1'b1;
                m_pat[f] = field_en[f] ? low_at(s) : '1;
                if (mode[f] && field_en[f])
                    m_end[f] = edge_num + ((hold_len == 0) ? 1 : int'(hold_len));
                else
                    m_end[f] = 0;
            end else if (edge_num == m_end[f]) begin
                m_pat[f] = '1;
            end
            m_prev[f] = strobe_n[f];
        end
        if (any_ovr) m_ovr = 1'b1;
        else if (clr_overrun[0]) m_ovr = 1'b0;
    endtask

    task automatic check_all();
        logic [31:0] e_out;
        logic [31:0] e_busy;
        e_out  = '0;
        e_busy = '0;
        for (int f = 0; f < FIELDS; f++) begin
            e_out[f*NOUT +: NOUT] = m_pat[f];
            e_busy[f] = (edge_num < m_end[f]);
        end
        chk("out_n", out_n, e_out);
        chk("busy", {28'd0, busy}, e_busy);
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    endtask

    task automatic tick();
        @(posedge main_clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_field(input int f, input int sel, input bit en, input bit md);
        field_sel[f*SEL_W +: SEL_W] = SEL_W'(sel);
        field_en[f] = en;
        mode[f]     = md;
    endtask

    // Strobe one field low for a single edge, then release it.
    task automatic strobe_one(input int f);
        strobe_n[f] = 1'b0;
        tick();
        strobe_n[f] = 1'b1;
    endtask

    initial begin
        int low_cnt;
        int bsy_cnt;

        tbl[0] = '{0, 5, 1'b1, 1'b0, 0,  8'hDF, 20, 0};
        tbl[1] = '{0, 2, 1'b1, 1'b0, 0,  8'hFB, 20, 0};
        tbl[2] = '{1, 0, 1'b1, 1'b1, 3,  8'hFE, 3,  3};
        tbl[3] = '{1, 0, 1'b1, 1'b1, 0,  8'hFE, 1,  1};
        tbl[4] = '{3, 4, 1'b0, 1'b0, 0,  8'hFF, 20, 0};
        tbl[5] = '{2, 6, 1'b1, 1'b1, 15, 8'hBF, 15, 15};
        tbl[6] = '{3, 1, 1'b1, 1'b1, 2,  8'hFD, 2,  2};
        tbl[7] = '{2, 3, 1'b0, 1'b1, 5,  8'hFF, 20, 0};

        res         = 1'b1;
        field_sel   = '0;
        field_en    = '0;
        strobe_n    = '1;
        mode        = '0;
        hold_len    = '0;
        clr_overrun = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge main_clk);
        @(posedge main_clk);
        #3 res = 1'b0;
        tick();

        // Table-driven single-field captures.
        for (int i = 0; i < 8; i++) begin
            set_field(tbl[i].f, tbl[i].sel, tbl[i].en, tbl[i].md);
            hold_len = HOLD_W'(tbl[i].hold);
            strobe_one(tbl[i].f);
            chk($sformatf("tbl%0d_pat", i), {24'd0, out_n[tbl[i].f*NOUT +: NOUT]}, {24'd0, tbl[i].pat});
            low_cnt = (out_n[tbl[i].f*NOUT +: NOUT] == tbl[i].pat) ? 1 : 0;
            bsy_cnt = busy[tbl[i].f] ? 1 : 0;
            // Inputs wander between captures; outputs must not follow.
            field_sel = FIELDS*SEL_W'($urandom);
            field_en  = FIELDS'($urandom);
            mode      = FIELDS'($urandom);
            hold_len  = HOLD_W'($urandom);
            for (int c = 1; c < 20; c++) begin
                tick();
                if (out_n[tbl[i].f*NOUT +: NOUT] == tbl[i].pat) low_cnt++;
                if (busy[tbl[i].f]) bsy_cnt++;
            end
            chk($sformatf("tbl%0d_low", i), low_cnt, tbl[i].low);
            chk($sformatf("tbl%0d_busy", i), bsy_cnt, tbl[i].bsy);
        end

        // Recapture while busy: new pattern, reload, overrun.
        set_field(2, 1, 1'b1, 1'b1);
        hold_len = 4'd6;
        strobe_one(2);
        tick();
        set_field(2, 7, 1'b1, 1'b1);
        strobe_one(2);
        chk("ovr_pat", {24'd0, out_n[23:16]}, 32'h7F);
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        bsy_cnt = busy[2] ? 1 : 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (busy[2]) bsy_cnt++;
        end
        chk("ovr_reload", bsy_cnt, 6);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);
        // Clear together with a fresh overrun: set wins.
        strobe_one(2);
        tick();
        clr_overrun = 1'b1;
        strobe_one(2);
        clr_overrun = 1'b0;
        chk("ovr_set_wins", {31'd0, overrun}, 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("ovr_clear", {31'd0, overrun}, 32'd0);
        for (int c = 0; c < 8; c++) tick();

        // Capture exactly on the expiry edge is not an overrun.
        set_field(1, 3, 1'b1, 1'b1);
        hold_len = 4'd2;
        strobe_one(1);
        tick();
        set_field(1, 4, 1'b1, 1'b1);
        strobe_one(1);
        chk("expiry_pat", {24'd0, out_n[15:8]}, 32'hEF);
        chk("expiry_no_ovr", {31'd0, overrun}, 32'd0);
        for (int c = 0; c < 4; c++) tick();

        // Long strobe: one capture only.
        set_field(3, 4, 1'b1, 1'b1);
        hold_len = 4'd2;
        strobe_n[3] = 1'b0;
        bsy_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (busy[3]) bsy_cnt++;
        end
        strobe_n[3] = 1'b1;
        tick();
        chk("long_busy", bsy_cnt, 2);
        chk("long_no_ovr", {31'd0, overrun}, 32'd0);

        // Reset mid-pulse with overrun pending, strobe low through release.
        set_field(1, 2, 1'b1, 1'b1);
        hold_len = 4'd8;
        strobe_one(1);
        tick();
        strobe_one(1);
        #2 res = 1'b1;
        #1;
        model_reset();
        chk("rst_out", out_n, 32'hFFFF_FFFF);
        chk("rst_busy", {28'd0, busy}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        strobe_n[0] = 1'b0;
        set_field(0, 6, 1'b1, 1'b0);
        @(posedge main_clk);
        #3 res = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk("rst_no_cap", {24'd0, out_n[7:0]}, 32'hFF);
        strobe_n[0] = 1'b1;
        tick();
        strobe_one(0);
        chk("rst_recap", {24'd0, out_n[7:0]}, 32'hBF);

        // All four fields captured on one edge.
        set_field(0, 3, 1'b1, 1'b0);
        set_field(1, 6, 1'b1, 1'b0);
        set_field(2, 1, 1'b1, 1'b0);
        set_field(3, 7, 1'b1, 1'b0);
        tick();
        strobe_n = '0;
        tick();
        strobe_n = '1;
        chk("concurrent", out_n, 32'h7FFD_BFF7);
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            field_sel   = FIELDS*SEL_W'($urandom);
            field_en    = FIELDS'($urandom);
            mode        = FIELDS'($urandom);
            hold_len    = HOLD_W'($urandom);
            clr_overrun = ($urandom_range(0, 9) == 0);
            for (int f = 0; f < FIELDS; f++)
                strobe_n[f] = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
